ser_reg_loader: RTL and testbench

- Serial-to-parallel write front end that sits directly upstream of the DFFE register banks.
- Deserialises address+data frames from a bit-serial control link, synchronous to the system clock.
- Drives the DFFE d bus and the per-bit ena lanes, so the addressed register captures one W-bit word per frame.
- Reports frame completion and framing/address errors to the control logic.

---
 rtl/ser_reg_loader.sv | 161 ++++++++++++++++
 tb/tb_ser_reg_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ser_reg_loader.sv
// Bit-serial frame deserialiser feeding the DFFE register banks: collects AW
// address bits and W data bits, then drives d and one register's ena lanes.
module ser_reg_loader #(
  parameter int W    = 8,
  parameter int AW   = 4,
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              sstb,
  input  logic              svld,
  input  logic              sdat,
  output logic [W-1:0]      d,
  output logic [NREG*W-1:0] ena,
  output logic              done,
  output logic              err
);

  localparam int MAXW = (AW > W) ? AW : W;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] AW_C = CW'(AW);
  localparam logic [CW-1:0] W_C  = CW'(W);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_WAITEND = 3'd3,
    S_COMMIT  = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s, cnt_inc_s;
  logic [AW-1:0]     addr_r, addr_s;
  logic [W-1:0]      data_r, data_s;
  logic [W-1:0]      d_s;
  logic [NREG*W-1:0] ena_s;
  logic              done_s, err_s, hit_s;

  // Next-state, shift-register and registered-output computation.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    data_s    = data_r;
    d_s       = d;
    ena_s     = '0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    hit_s     = 1'b0;
    cnt_inc_s = cnt_r + CW'(1);

    case (state_r)
      // IDLE behaves like ADDR once sstb is seen, so a bit on the rising cycle counts.
      S_IDLE, S_ADDR: begin
        if (!sstb) begin
          cnt_s   = '0;
          state_s = S_IDLE;
          if (state_r == S_ADDR) begin
            err_s = 1'b1;
          end else begin
            err_s = 1'b0;
          end
        end else if (svld) begin
          addr_s = AW'({addr_r, sdat});
          if (cnt_inc_s == AW_C) begin
            state_s = S_DATA;
            cnt_s   = '0;
          end else begin
            state_s = S_ADDR;
            cnt_s   = cnt_inc_s;
          end
        end else begin
          state_s = S_ADDR;
        end
      end
      S_DATA: begin
        if (!sstb) begin
          err_s   = 1'b1;
          state_s = S_IDLE;
          cnt_s   = '0;
        end else if (svld) begin
          data_s = W'({data_r, sdat});
          if (cnt_inc_s == W_C) begin
            state_s = S_WAITEND;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_WAITEND: begin
        if (sstb && svld) begin
          state_s = S_ERR;
        end else if (!sstb) begin
          state_s = S_COMMIT;
          for (int k = 0; k < NREG; k++) begin
            if (addr_r == AW'(k)) begin
              ena_s[k*W +: W] = '1;
              hit_s           = 1'b1;
            end else begin
              ena_s[k*W +: W] = '0;
            end
          end
          if (hit_s) begin
            d_s    = data_r;
            done_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = S_WAITEND;
        end
      end
      S_COMMIT: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
      S_ERR: begin
        if (!sstb) begin
          err_s   = 1'b1;
          state_s = S_IDLE;
          cnt_s   = '0;
        end else begin
          state_s = S_ERR;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, shift registers and output registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      d       <= '0;
      ena     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      d       <= d_s;
      ena     <= ena_s;
      done    <= done_s;
      err     <= err_s;
    end
  end

endmodule

// File: tb/tb_ser_reg_loader.sv
// Directed bench for ser_reg_loader: two instances (NREG=16 and NREG=10) share
// one serial stimulus and are checked against hand-computed expectations.
module tb_ser_reg_loader;

  logic         clk, clrn, sstb, svld, sdat;
  logic [7:0]   d16, d10;
  logic [127:0] ena16;
  logic [79:0]  ena10;
  logic         done16, err16, done10, err10;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]   addr;
    logic [7:0]   data;
    bit           gap;
    logic [1:0]   mode;    // 0 normal, 1 overlong, 2 abort after 2 data bits
    logic [127:0] e_ena16;
    logic [7:0]   e_d16;
    bit           e_done16;
    bit           e_err16;
    logic [79:0]  e_ena10;
    logic [7:0]   e_d10;
    bit           e_done10;
    bit           e_err10;
  } vec_t;

  vec_t vecs[10];
  vec_t sv;

  ser_reg_loader #(.W(8), .AW(4), .NREG(16)) dut16 (
    .clk(clk), .clrn(clrn), .sstb(sstb), .svld(svld), .sdat(sdat),
    .d(d16), .ena(ena16), .done(done16), .err(err16)
  );

  ser_reg_loader #(.W(8), .AW(4), .NREG(10)) dut10 (
    .clk(clk), .clrn(clrn), .sstb(sstb), .svld(svld), .sdat(sdat),
    .d(d10), .ena(ena10), .done(done10), .err(err10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_frame(input logic [3:0] a, input logic [7:0] dd, input bit gap,
                             input logic [1:0] mode);
    logic [11:0] bits;
    int          nb;
    bits = {a, dd};
    nb   = (mode == 2'd2) ? 6 : 12;
    for (int i = 0; i < nb; i++) begin
      sstb = 1'b1; svld = 1'b1; sdat = bits[11-i];
      tick();
      if (gap) begin
        svld = 1'b0; sdat = ~bits[11-i];
        tick();
      end
    end
    if (mode == 2'd1) begin
      sstb = 1'b1; svld = 1'b1; sdat = 1'b1;
      tick();
    end
    sstb = 1'b0; svld = 1'b0; sdat = 1'b0;
  endtask

  // First sample after the edge that sees sstb low: the commit/err cycle.
  task automatic check_window(input vec_t v, input int quiet);
    tick();
    chk("ena16",  ena16,           v.e_ena16);
    chk("d16",    128'(d16),       128'(v.e_d16));
    chk("done16", 128'(done16),    128'(v.e_done16));
    chk("err16",  128'(err16),     128'(v.e_err16));
    chk("ena10",  128'(ena10),     128'(v.e_ena10));
    chk("d10",    128'(d10),       128'(v.e_d10));
    chk("done10", 128'(done10),    128'(v.e_done10));
    chk("err10",  128'(err10),     128'(v.e_err10));
    for (int q = 0; q < quiet; q++) begin
      tick();
      chk("ena16_quiet", ena16, 128'd0);
      chk("ena10_quiet", 128'(ena10), 128'd0);
      chk("pulse_quiet", 128'({done16, err16, done10, err10}), 128'd0);
      chk("d16_hold", 128'(d16), 128'(v.e_d16));
      chk("d10_hold", 128'(d10), 128'(v.e_d10));
    end
  endtask

  initial begin
    vecs[0] = '{4'h3, 8'hA5, 1'b0, 2'd0, 128'hFF << 24,  8'hA5, 1'b1, 1'b0, 80'hFF << 24, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{4'h3, 8'hA5, 1'b1, 2'd0, 128'hFF << 24,  8'hA5, 1'b1, 1'b0, 80'hFF << 24, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{4'hC, 8'h55, 1'b0, 2'd0, 128'hFF << 96,  8'h55, 1'b1, 1'b0, 80'h0,        8'hA5, 1'b0, 1'b1};
    vecs[3] = '{4'h1, 8'hC3, 1'b0, 2'd2, 128'h0,         8'h55, 1'b0, 1'b1, 80'h0,        8'hA5, 1'b0, 1'b1};
    vecs[4] = '{4'h1, 8'h0F, 1'b0, 2'd0, 128'hFF << 8,   8'h0F, 1'b1, 1'b0, 80'hFF << 8,  8'h0F, 1'b1, 1'b0};
    vecs[5] = '{4'h2, 8'h3C, 1'b0, 2'd1, 128'h0,         8'h0F, 1'b0, 1'b1, 80'h0,        8'h0F, 1'b0, 1'b1};
    vecs[6] = '{4'h9, 8'h81, 1'b1, 2'd0, 128'hFF << 72,  8'h81, 1'b1, 1'b0, 80'hFF << 72, 8'h81, 1'b1, 1'b0};
    vecs[7] = '{4'hA, 8'h66, 1'b0, 2'd0, 128'hFF << 80,  8'h66, 1'b1, 1'b0, 80'h0,        8'h81, 1'b0, 1'b1};
    vecs[8] = '{4'hF, 8'h7E, 1'b1, 2'd0, 128'hFF << 120, 8'h7E, 1'b1, 1'b0, 80'h0,        8'h81, 1'b0, 1'b1};
    vecs[9] = '{4'h0, 8'h5A, 1'b0, 2'd0, 128'hFF,        8'h5A, 1'b1, 1'b0, 80'hFF,       8'h5A, 1'b1, 1'b0};

    clrn = 1'b0; sstb = 1'b0; svld = 1'b0; sdat = 1'b0;
    #3;
    chk("rst_d16",   128'(d16), 128'd0);
    chk("rst_ena16", ena16, 128'd0);
    chk("rst_ena10", 128'(ena10), 128'd0);
    chk("rst_pulse", 128'({done16, err16, done10, err10}), 128'd0);
    #9 clrn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive_frame(vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].mode);
      check_window(vecs[i], 3);
    end

    // Reset asserted during the DATA phase clears outputs immediately.
    for (int i = 0; i < 7; i++) begin
      sstb = 1'b1; svld = 1'b1; sdat = (i < 4) ? 1'b0 : 1'b1;
      tick();
    end
    clrn = 1'b0;
    #1;
    chk("mrst_d16",   128'(d16), 128'd0);
    chk("mrst_d10",   128'(d10), 128'd0);
    chk("mrst_ena16", ena16, 128'd0);
    chk("mrst_pulse", 128'({done16, err16, done10, err10}), 128'd0);
    sstb = 1'b0; svld = 1'b0; sdat = 1'b0;
    #1 clrn = 1'b1;
    tick();
    sv = '{4'h0, 8'hFF, 1'b0, 2'd0, 128'hFF, 8'hFF, 1'b1, 1'b0, 80'hFF, 8'hFF, 1'b1, 1'b0};
    drive_frame(4'h0, 8'hFF, 1'b0, 2'd0);
    check_window(sv, 2);

    // Back-to-back: a bit presented during COMMIT must be ignored.
    sv = '{4'h5, 8'h12, 1'b0, 2'd0, 128'hFF << 40, 8'h12, 1'b1, 1'b0, 80'hFF << 40, 8'h12, 1'b1, 1'b0};
    drive_frame(4'h5, 8'h12, 1'b0, 2'd0);
    check_window(sv, 0);
    sstb = 1'b1; svld = 1'b1; sdat = 1'b1;
    tick();
    chk("b2b_ena16_off", ena16, 128'd0);
    chk("b2b_pulse_off", 128'({done16, err16, done10, err10}), 128'd0);
    sv = '{4'h6, 8'h34, 1'b0, 2'd0, 128'hFF << 48, 8'h34, 1'b1, 1'b0, 80'hFF << 48, 8'h34, 1'b1, 1'b0};
    drive_frame(4'h6, 8'h34, 1'b0, 2'd0);
    check_window(sv, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
